dial_emu_multi: RTL and testbench

Parametrised digital-to-dial emulator that turns per-player up/down (inc/dec) button levels into spinner/dial signals for arcade cores.
- Sits between the joystick mux (USB/DB9/DB15 merged) and the core's player input bytes; replaces per-game ad-hoc combinational dial logic.
- Supports N channels and two output modes: 2-bit quadrature, and the legacy level code (01 = dec, 10 = inc, 11 = idle).
- Adds a runtime step rate, a per-channel direction invert, hold-to-accelerate and a wrapping position counter per channel.

---
 rtl/dial_emu_multi.sv | 175 +++++++++++++++++
 tb/tb_dial_emu_multi.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dial_emu_multi.sv
// Digital-to-dial emulator: turns per-player inc/dec button levels into
// quadrature or legacy level-code dial signals, with a shared step-rate
// prescaler, per-channel invert, hold acceleration and a wrapping position.
module dial_emu_multi #(
   parameter int CHANNELS  = 2,
   parameter int DIV_W     = 16,
   parameter int CNT_W     = 8,
   parameter int ACCEL_EN  = 1,
   parameter int ACC_STEPS = 16
) (
   input  logic                      clk_sys,
   input  logic                      reset_n,
   input  logic [CHANNELS-1:0]       enable,
   input  logic [CHANNELS-1:0]       invert,
   input  logic                      mode,
   input  logic [DIV_W-1:0]          rate,
   input  logic [CHANNELS-1:0]       btn_inc,
   input  logic [CHANNELS-1:0]       btn_dec,
   output logic [2*CHANNELS-1:0]     dial_out,
   output logic [CNT_W*CHANNELS-1:0] position,
   output logic                      tick
);

   localparam int         SW      = $clog2(ACC_STEPS + 1);
   localparam logic [2:0] IV_INIT = (ACCEL_EN != 0) ? 3'd4 : 3'd1;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} ch_state_t;

   logic [DIV_W-1:0] pre_cnt;
   logic             wrap;
   logic             mode_q;
   logic             mode_chg;

   assign wrap     = (pre_cnt == rate);
   assign tick     = reset_n & wrap;
   assign mode_chg = mode ^ mode_q;

   // Prescaler: counts 0..rate; an over-range count after a rate drop restarts at 0.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) pre_cnt <= '0;
      else if (pre_cnt >= rate) pre_cnt <= '0;
      else pre_cnt <= pre_cnt + 1'b1;
   end

   // Previous mode, used to detect a mode change on any clock.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) mode_q <= 1'b0;
      else mode_q <= mode;
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      ch_state_t        st, st_n;
      logic             ldir, ldir_n;
      logic [2:0]       sub, sub_n, iv, iv_n;
      logic [SW-1:0]    stp, stp_n;
      logic [1:0]       dial, dial_n, level;
      logic [CNT_W-1:0] pos, pos_n;
      logic             d_inc, d_dec, d_none, step;

      // Channel state register.
      always_ff @(posedge clk_sys or negedge reset_n) begin
         if (!reset_n) begin
            st   <= ST_IDLE;
            ldir <= 1'b0;
            sub  <= '0;
            iv   <= IV_INIT;
            stp  <= '0;
            dial <= 2'b11;
            pos  <= '0;
         end else begin
            st   <= st_n;
            ldir <= ldir_n;
            sub  <= sub_n;
            iv   <= iv_n;
            stp  <= stp_n;
            dial <= dial_n;
            pos  <= pos_n;
         end
      end

      // Next-state, step timing, acceleration and dial encoding.
      always_comb begin
         st_n   = st;
         ldir_n = ldir;
         sub_n  = sub;
         iv_n   = iv;
         stp_n  = stp;
         dial_n = dial;
         pos_n  = pos;
         step   = 1'b0;
         d_inc  = invert[k] ? btn_dec[k] : btn_inc[k];
         d_dec  = invert[k] ? btn_inc[k] : btn_dec[k];
         d_none = (d_inc == d_dec);
         // level code lags the state by one clock because it is built from the current state
         level  = (st == ST_RUN) ? (ldir ? 2'b10 : 2'b01) : 2'b11;

         if (mode_chg || !enable[k]) begin
            st_n   = ST_IDLE;
            sub_n  = '0;
            stp_n  = '0;
            iv_n   = IV_INIT;
            dial_n = 2'b11;
         end else begin
            case (st)
               ST_IDLE: begin
                  if (!d_none) begin
                     st_n   = ST_RUN;
                     ldir_n = d_inc;
                     sub_n  = '0;
                     stp_n  = '0;
                     iv_n   = IV_INIT;
                  end
               end
               ST_RUN: begin
                  if (d_none) begin
                     st_n  = ST_IDLE;
                     sub_n = '0;
                     stp_n = '0;
                     iv_n  = IV_INIT;
                  end else if (d_inc != ldir) begin
                     st_n = ST_GAP;
                  end else if (wrap) begin
                     if (sub + 3'd1 == iv) begin
                        step  = 1'b1;
                        sub_n = '0;
                        if (ACCEL_EN != 0) begin
                           if (stp == SW'(ACC_STEPS - 1)) begin
                              stp_n = '0;
                              iv_n  = (iv > 3'd1) ? (iv >> 1) : 3'd1;
                           end else begin
                              stp_n = stp + 1'b1;
                           end
                        end
                     end else begin
                        sub_n = sub + 3'd1;
                     end
                  end
               end
               ST_GAP: begin
                  if (wrap) begin
                     st_n   = d_none ? ST_IDLE : ST_RUN;
                     ldir_n = d_none ? ldir : d_inc;
                     sub_n  = '0;
                     stp_n  = '0;
                     iv_n   = IV_INIT;
                  end
               end
               default: st_n = ST_IDLE;
            endcase

            if (step) pos_n = ldir ? pos + 1'b1 : pos - 1'b1;

            if (mode) begin
               dial_n = level;
            end else if (step) begin
               case ({ldir, dial})
                  3'b1_11: dial_n = 2'b10;
                  3'b1_10: dial_n = 2'b00;
                  3'b1_00: dial_n = 2'b01;
                  3'b1_01: dial_n = 2'b11;
                  3'b0_11: dial_n = 2'b01;
                  3'b0_01: dial_n = 2'b00;
                  3'b0_00: dial_n = 2'b10;
                  3'b0_10: dial_n = 2'b11;
                  default: dial_n = 2'b11;
               endcase
            end
         end
      end

      assign dial_out[2*k +: 2]         = dial;
      assign position[CNT_W*k +: CNT_W] = pos;
   end

endmodule

// File: tb/tb_dial_emu_multi.sv
// Bench for dial_emu_multi: an accelerating and a fixed-interval instance share
// the same stimulus and are checked every cycle against a behavioural model,
// plus directed spot values.
module tb_dial_emu_multi;

   localparam int CH  = 2;
   localparam int ACC = 16;

   logic          clk_sys = 1'b0;
   logic          reset_n;
   logic [CH-1:0] enable, invert, btn_inc, btn_dec;
   logic          mode;
   logic [15:0]   rate;
   logic [2*CH-1:0] dial_a, dial_f;
   logic [8*CH-1:0] pos_a, pos_f;
   logic          tick_a, tick_f;

   int n_cmp = 0;
   int n_bad = 0;

   // model state, index [instance][channel]; instance 0 accelerates, 1 is fixed
   int m_act[2][CH], m_gap[2][CH], m_ldir[2][CH], m_ticks[2][CH];
   int m_nst[2][CH], m_pos[2][CH], m_ph[2][CH], m_dial[2][CH];
   int m_cnt, m_mode_q;
   int QPH[4] = '{3, 2, 0, 1};

   always #5 clk_sys = ~clk_sys;

   dial_emu_multi #(.CHANNELS(CH), .DIV_W(16), .CNT_W(8), .ACCEL_EN(1), .ACC_STEPS(ACC)) dut_a (
      .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .invert(invert), .mode(mode),
      .rate(rate), .btn_inc(btn_inc), .btn_dec(btn_dec), .dial_out(dial_a),
      .position(pos_a), .tick(tick_a));

   dial_emu_multi #(.CHANNELS(CH), .DIV_W(16), .CNT_W(8), .ACCEL_EN(0), .ACC_STEPS(ACC)) dut_f (
      .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .invert(invert), .mode(mode),
      .rate(rate), .btn_inc(btn_inc), .btn_dec(btn_dec), .dial_out(dial_f),
      .position(pos_f), .tick(tick_f));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < CH; c++) begin
            m_act[d][c] = 0; m_gap[d][c] = 0; m_ldir[d][c] = 0; m_ticks[d][c] = 0;
            m_nst[d][c] = 0; m_pos[d][c] = 0; m_ph[d][c] = 0; m_dial[d][c] = 3;
         end
      m_cnt = 0;
      m_mode_q = 0;
   endtask

   task automatic model_edge();
      int tk, mchg, ie, de, none, lvl, step, iv;
      tk   = (m_cnt == int'(rate)) ? 1 : 0;
      mchg = (int'(mode) != m_mode_q) ? 1 : 0;
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < CH; c++) begin
            ie   = int'(btn_inc[c] ^ (invert[c] & (btn_inc[c] | btn_dec[c])));
            de   = int'(btn_dec[c] ^ (invert[c] & (btn_inc[c] | btn_dec[c])));
            none = (ie == de) ? 1 : 0;
            lvl  = (m_act[d][c] != 0 && m_gap[d][c] == 0) ? (m_ldir[d][c] != 0 ? 2 : 1) : 3;
            step = 0;
            if (mchg != 0 || !enable[c]) begin
               m_act[d][c] = 0; m_gap[d][c] = 0; m_ticks[d][c] = 0; m_nst[d][c] = 0;
               m_dial[d][c] = 3; m_ph[d][c] = 0;
            end else begin
               if (m_act[d][c] == 0) begin
                  if (none == 0) begin
                     m_act[d][c] = 1; m_ldir[d][c] = ie; m_ticks[d][c] = 0; m_nst[d][c] = 0;
                  end
               end else if (m_gap[d][c] == 0) begin
                  if (none != 0) m_act[d][c] = 0;
                  else if (ie != m_ldir[d][c]) m_gap[d][c] = 1;
                  else if (tk != 0) begin
                     m_ticks[d][c]++;
                     if (d == 1 || m_nst[d][c] >= 2 * ACC) iv = 1;
                     else iv = 4 >> (m_nst[d][c] / ACC);
                     if (m_ticks[d][c] >= iv) begin
                        step = 1; m_ticks[d][c] = 0; m_nst[d][c]++;
                     end
                  end
               end else if (tk != 0) begin
                  m_gap[d][c] = 0;
                  if (none != 0) m_act[d][c] = 0;
                  else begin
                     m_ldir[d][c] = ie; m_ticks[d][c] = 0; m_nst[d][c] = 0;
                  end
               end
               if (step != 0) m_pos[d][c] = (m_pos[d][c] + (m_ldir[d][c] != 0 ? 1 : 255)) % 256;
               if (mode) m_dial[d][c] = lvl;
               else if (step != 0) begin
                  m_ph[d][c] = (m_ph[d][c] + (m_ldir[d][c] != 0 ? 1 : 3)) % 4;
                  m_dial[d][c] = QPH[m_ph[d][c]];
               end
            end
         end
      m_cnt = (m_cnt >= int'(rate)) ? 0 : m_cnt + 1;
      m_mode_q = int'(mode);
   endtask

   task automatic check_all();
      chk("tick_a", 32'(tick_a), (m_cnt == int'(rate)) ? 1 : 0);
      chk("tick_f", 32'(tick_f), (m_cnt == int'(rate)) ? 1 : 0);
      for (int c = 0; c < CH; c++) begin
         chk($sformatf("dial_a c%0d", c), 32'(dial_a[2*c +: 2]), m_dial[0][c]);
         chk($sformatf("dial_f c%0d", c), 32'(dial_f[2*c +: 2]), m_dial[1][c]);
         chk($sformatf("pos_a c%0d", c), 32'(pos_a[8*c +: 8]), m_pos[0][c]);
         chk($sformatf("pos_f c%0d", c), 32'(pos_f[8*c +: 8]), m_pos[1][c]);
      end
   endtask

   task automatic cyc();
      @(posedge clk_sys);
      model_edge();
      @(negedge clk_sys);
      check_all();
   endtask

   task automatic cycn(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic rand_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(7) == 0)  btn_inc = 2'($urandom);
         if ($urandom_range(7) == 0)  btn_dec = 2'($urandom);
         if ($urandom_range(31) == 0) invert  = 2'($urandom);
         if ($urandom_range(31) == 0) enable  = enable ^ 2'(1 << $urandom_range(1));
         if ($urandom_range(63) == 0) mode    = ~mode;
         if ($urandom_range(47) == 0) rate    = 16'($urandom_range(3));
         cyc();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; enable = '1; invert = '0; mode = 1'b0; rate = 16'd3;
      btn_inc = '0; btn_dec = '0;
      model_reset();
      repeat (3) @(negedge clk_sys);
      chk("reset dial_a", 32'(dial_a), 32'hF);
      chk("reset pos_f", 32'(pos_f), 0);
      chk("reset tick_a", 32'(tick_a), 0);
      reset_n = 1'b1;
      cycn(3);

      // fixed interval quadrature at rate 3
      for (int i = 0; i < 8 && m_cnt != 3; i++) cyc();
      cyc();
      btn_inc[0] = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         cyc();
         if (i == 4)  chk("quad ph1", 32'(dial_f[1:0]), 2);
         if (i == 8)  chk("quad ph2", 32'(dial_f[1:0]), 0);
         if (i == 12) chk("quad ph3", 32'(dial_f[1:0]), 1);
      end
      chk("quad ph4", 32'(dial_f[1:0]), 3);
      chk("quad pos_f", 32'(pos_f[7:0]), 4);
      chk("quad pos_a", 32'(pos_a[7:0]), 1);
      btn_inc[0] = 1'b0;
      cycn(3);

      // acceleration with wrap at rate 0 on channel 1
      rate = 16'd0;
      cycn(2);
      btn_inc[1] = 1'b1;
      cycn(9);
      chk("accel start pos_a", 32'(pos_a[15:8]), 2);
      chk("accel start pos_f", 32'(pos_f[15:8]), 8);
      btn_inc[1] = 1'b0;
      cyc();
      btn_dec[1] = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         cyc();
         if (i == 9)  chk("accel to zero", 32'(pos_a[15:8]), 8'h00);
         if (i == 13) chk("accel wrap", 32'(pos_a[15:8]), 8'hFF);
         if (i == 97) chk("accel half", 32'(pos_a[15:8]), 8'hE2);
         if (i == 98) chk("accel full", 32'(pos_a[15:8]), 8'hE1);
      end
      chk("accel end pos_a", 32'(pos_a[15:8]), 8'hDF);
      chk("accel end pos_f", 32'(pos_f[15:8]), 8'hA5);
      btn_dec[1] = 1'b0;
      cycn(2);

      // level mode reversal
      mode = 1'b1;
      cycn(3);
      btn_inc[0] = 1'b1;
      cycn(3);
      chk("level inc", 32'(dial_a[1:0]), 2);
      btn_inc[0] = 1'b0; btn_dec[0] = 1'b1;
      cyc(); chk("level rev0", 32'(dial_a[1:0]), 2);
      cyc(); chk("level gap", 32'(dial_a[1:0]), 3);
      cyc(); chk("level dec", 32'(dial_f[1:0]), 1);
      cycn(3);
      btn_dec[0] = 1'b0;
      cyc(); chk("level rel0", 32'(dial_a[1:0]), 1);
      cyc(); chk("level idle", 32'(dial_a[1:0]), 3);

      // invert and both pressed on channel 1
      mode = 1'b0;
      cycn(2);
      invert = 2'b10; btn_inc[1] = 1'b1;
      cycn(2); chk("inv ph1", 32'(dial_f[3:2]), 1);
      cyc();   chk("inv ph2", 32'(dial_f[3:2]), 0);
      chk("inv pos", 32'(pos_f[15:8]), 8'hA3);
      btn_dec[1] = 1'b1;
      cycn(5);
      chk("both pos", 32'(pos_f[15:8]), 8'hA3);
      chk("both dial", 32'(dial_f[3:2]), 0);
      btn_inc[1] = 1'b0; btn_dec[1] = 1'b0; invert = '0;
      cycn(2);

      // enable drop mid-run, then mode toggle with a channel running
      btn_inc[0] = 1'b1;
      cycn(6);
      enable[0] = 1'b0;
      cyc();
      chk("en drop f", 32'(dial_f[1:0]), 3);
      chk("en drop a", 32'(dial_a[1:0]), 3);
      cycn(4);
      enable[0] = 1'b1; btn_inc[0] = 1'b0;
      cycn(2);
      btn_inc[1] = 1'b1;
      cycn(2);
      chk("pre toggle", 32'(dial_f[3:2]), 1);
      mode = 1'b1;
      cyc();
      chk("toggle all", 32'(dial_f), 32'hF);
      mode = 1'b0; btn_inc[1] = 1'b0;
      cycn(3);

      // randomized traffic
      rand_cycles(400);

      // asynchronous reset mid-run
      enable = '1; mode = 1'b0; rate = 16'd0; btn_inc = 2'b11; btn_dec = '0;
      cycn(20);
      #2 reset_n = 1'b0;
      #1;
      chk("async dial_a", 32'(dial_a), 32'hF);
      chk("async dial_f", 32'(dial_f), 32'hF);
      chk("async pos_a", 32'(pos_a), 0);
      chk("async pos_f", 32'(pos_f), 0);
      chk("async tick", 32'({tick_a, tick_f}), 0);
      model_reset();
      @(negedge clk_sys);
      reset_n = 1'b1;
      rand_cycles(150);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
